mips_mc_control: RTL and testbench
==================================

Name: mips_mc_control

Overview:
Multicycle main controller for the MIPS datapath. It sits directly upstream of the ALU and drives its 8-bit control word alu_in = {aluop[1:0], func[5:0]}. It also drives every datapath enable and mux select, and sequences each instruction through fetch, decode, execute, memory and writeback states. It consumes the opcode and funct fields from the instruction register, the ALU zero flag, and a memory-ready handshake.

Parameters:
FETCH_WAIT_MAX, 8, cycles FETCH/MEMRD/MEMWR may stall on mem_ready before mem_timeout pulses; 0 disables the timeout.

Ports:
clk  in  1  clock; all state updates on the rising edge
rst_n  in  1  synchronous active-low reset
opcode  in  6  instr[31:26] from the instruction register; stable after FETCH completes
funct  in  6  instr[5:0] from the instruction register
zero  in  1  ALU zero flag
mem_ready  in  1  memory completes the current access this cycle
alu_in  out  8  {aluop, func} to the ALU
pc_en  out  1  PC write enable, branch/zero gating included
iord  out  1  memory address select: 0 = PC, 1 = ALU result register
mem_write  out  1  memory write strobe
ir_write  out  1  instruction register load
reg_dst  out  1  destination select: 0 = rt, 1 = rd
mem_to_reg  out  1  writeback data select: 0 = ALU result, 1 = memory data
reg_write  out  1  register file write enable
alu_src_a  out  1  ALU A select: 0 = PC, 1 = rs
alu_src_b  out  2  ALU B select: 00 = rt, 01 = const 4, 10 = immediate, 11 = immediate<<2
imm_zext  out  1  immediate extension: 1 = zero-extend (ORI), 0 = sign-extend
pc_src  out  2  PC source: 00 = ALU, 01 = ALU result register, 10 = jump target
illegal_op  out  1  one-cycle pulse on an unknown opcode in DECODE
mem_timeout  out  1  one-cycle pulse when a memory wait exceeds FETCH_WAIT_MAX
state_dbg  out  4  current state encoding

Behaviour:
- State register, 4 bits. Encoding: FETCH=0, DECODE=1, MEMADR=2, MEMRD=3, MEMWB=4, MEMWR=5, EXECUTE=6, ALUWB=7, BRANCH=8, ADDIEX=9, IMMWB=10, ORIEX=11, JUMP=12. Codes 13-15 go to FETCH on the next edge.
- Reset: rst_n=0 at a clock edge puts the state in FETCH and clears the wait counter.
- While rst_n=0, these are forced 0 combinationally: pc_en, ir_write, mem_write, reg_write, illegal_op, mem_timeout. All other outputs take their FETCH values.
- Reset mid-instruction aborts the instruction. No register or memory write occurs in the reset cycle.
- Default value of every output is 0. alu_in[5:0] = 000000 unless aluop = 10.
- Per-state outputs (everything not listed is 0):
  - FETCH: alu_src_b=01, aluop=00, ir_write=mem_ready, pc_en=mem_ready. Stay in FETCH until mem_ready, then go to DECODE.
  - DECODE: alu_src_b=11, aluop=00. Next state by opcode: 100011 or 101011 -> MEMADR; 000000 -> EXECUTE; 000100 -> BRANCH; 001000 -> ADDIEX; 001101 -> ORIEX; 000010 -> JUMP. Any other opcode -> FETCH with illegal_op=1.
  - MEMADR: alu_src_a=1, alu_src_b=10, aluop=00. Next: MEMRD for lw, MEMWR for sw.
  - MEMRD: iord=1. Wait for mem_ready, then MEMWB.
  - MEMWB: mem_to_reg=1, reg_write=1. Next: FETCH.
  - MEMWR: iord=1, mem_write=1, held high throughout the wait. On mem_ready go to FETCH.
  - EXECUTE: alu_src_a=1, alu_src_b=00, alu_in={10, funct}. Next: ALUWB.
  - ALUWB: reg_dst=1, reg_write=1. Next: FETCH.
  - BRANCH: alu_src_a=1, aluop=01, pc_src=01, pc_en=zero. Next: FETCH.
  - ADDIEX: alu_src_a=1, alu_src_b=10, aluop=00. Next: IMMWB.
  - ORIEX: alu_src_a=1, alu_src_b=10, imm_zext=1, aluop=11. Next: IMMWB.
  - IMMWB: reg_write=1. Next: FETCH.
  - JUMP: pc_src=10, pc_en=1. Next: FETCH.
- Latency with mem_ready held at 1: lw=5, sw=4, R-type=4, addi=4, ori=4, beq=3, j=3 cycles. Each stall cycle adds 1.
- Wait counter:
  - Counts consecutive stall cycles in FETCH, MEMRD and MEMWR; it is cleared on any state change.
  - When the count reaches FETCH_WAIT_MAX, mem_timeout pulses for 1 cycle, the counter is cleared, and the state is kept (no abort).
- mem_ready and zero are sampled only in the states that use them and are ignored elsewhere.

Optional Feature:
BNE_SUPPORT_EN
- Defined: opcode 000101 in DECODE goes to BRANCH. In BRANCH, pc_en = ~zero when opcode = 000101, otherwise pc_en = zero.
- Undefined: opcode 000101 is illegal and pulses illegal_op.

Test Plan:
- rst_n=0 for 2 cycles with mem_ready=1 -> state_dbg=0, all enables 0. After release: ir_write=1, pc_en=1, alu_in=0x00.
- R-type, opcode=000000, funct=100010 -> states 0,1,6,7,0. In EXECUTE alu_in=0xA2; in ALUWB reg_write=1 and reg_dst=1.
- lw with mem_ready low for 3 cycles in MEMRD -> 8 cycles total; reg_write and mem_to_reg are 1 only in MEMWB.
- beq -> pc_en=1 in BRANCH with zero=1, and pc_en=0 with zero=0; alu_in=0x40 in both cases.
- ori -> alu_in=0xC0 and imm_zext=1 in ORIEX. Opcode 111111 -> illegal_op pulses once and the next state is FETCH.
- FETCH_WAIT_MAX=8 with mem_ready=0 held for 10 cycles in FETCH -> mem_timeout pulses after the 8th stall cycle and the state stays FETCH.

Source files
------------

// File: rtl/mips_mc_control.sv
`default_nettype none
// +--------------------------------------------------------------------------+
// | mips_mc_control : multicycle MIPS main controller (FSM + memory-wait      |
// |                   watchdog). Optional BNE_SUPPORT_EN adds bne decoding.   |
// | Revision 1.0                                                              |
// +--------------------------------------------------------------------------+
module mips_mc_control #(
  parameter int FETCH_WAIT_MAX = 8
) (
  input  logic       clk,
  input  logic       rst_n,
  input  logic [5:0] opcode,
  input  logic [5:0] funct,
  input  logic       zero,
  input  logic       mem_ready,
  output logic [7:0] alu_in,
  output logic       pc_en,
  output logic       iord,
  output logic       mem_write,
  output logic       ir_write,
  output logic       reg_dst,
  output logic       mem_to_reg,
  output logic       reg_write,
  output logic       alu_src_a,
  output logic [1:0] alu_src_b,
  output logic       imm_zext,
  output logic [1:0] pc_src,
  output logic       illegal_op,
  output logic       mem_timeout,
  output logic [3:0] state_dbg
);

  typedef enum logic [3:0] {
    S_FETCH   = 4'd0,
    S_DECODE  = 4'd1,
    S_MEMADR  = 4'd2,
    S_MEMRD   = 4'd3,
    S_MEMWB   = 4'd4,
    S_MEMWR   = 4'd5,
    S_EXECUTE = 4'd6,
    S_ALUWB   = 4'd7,
    S_BRANCH  = 4'd8,
    S_ADDIEX  = 4'd9,
    S_IMMWB   = 4'd10,
    S_ORIEX   = 4'd11,
    S_JUMP    = 4'd12
  } state_t;

  localparam logic [5:0] OP_RTYPE = 6'b000000;
  localparam logic [5:0] OP_LW    = 6'b100011;
  localparam logic [5:0] OP_SW    = 6'b101011;
  localparam logic [5:0] OP_BEQ   = 6'b000100;
  localparam logic [5:0] OP_BNE   = 6'b000101;
  localparam logic [5:0] OP_ADDI  = 6'b001000;
  localparam logic [5:0] OP_ORI   = 6'b001101;
  localparam logic [5:0] OP_J     = 6'b000010;

  localparam int              CNT_W    = (FETCH_WAIT_MAX < 1) ? 1 : $clog2(FETCH_WAIT_MAX + 1);
  localparam logic [CNT_W-1:0] WAIT_MAX = CNT_W'(FETCH_WAIT_MAX);

  state_t           state_q, state_d, state_eff;
  logic [CNT_W-1:0] wait_cnt_q, wait_cnt_d;
  logic [1:0]       aluop;
  logic             in_wait, stall, timeout;

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state_q    <= S_FETCH;
      wait_cnt_q <= '0;
    end else begin
      state_q    <= state_d;
      wait_cnt_q <= wait_cnt_d;
    end
  end

  // While in reset, outputs decode as FETCH; enables are squashed below.
  always_comb begin
    state_eff = rst_n ? state_q : S_FETCH;
    in_wait   = rst_n && (state_q == S_FETCH || state_q == S_MEMRD || state_q == S_MEMWR);
    stall     = in_wait && !mem_ready;
    timeout   = (FETCH_WAIT_MAX != 0) && in_wait && (wait_cnt_q == WAIT_MAX);
    wait_cnt_d = (stall && !timeout) ? wait_cnt_q + CNT_W'(1) : '0;
  end

  always_comb begin
    state_d    = S_FETCH;
    aluop      = 2'b00;
    pc_en      = 1'b0;
    iord       = 1'b0;
    mem_write  = 1'b0;
    ir_write   = 1'b0;
    reg_dst    = 1'b0;
    mem_to_reg = 1'b0;
    reg_write  = 1'b0;
    alu_src_a  = 1'b0;
    alu_src_b  = 2'b00;
    imm_zext   = 1'b0;
    pc_src     = 2'b00;
    illegal_op = 1'b0;

    case (state_eff)
      S_FETCH: begin
        alu_src_b = 2'b01;
        ir_write  = mem_ready;
        pc_en     = mem_ready;
        state_d   = mem_ready ? S_DECODE : S_FETCH;
      end
      S_DECODE: begin
        alu_src_b = 2'b11;
        case (opcode)
          OP_LW, OP_SW: state_d = S_MEMADR;
          OP_RTYPE:     state_d = S_EXECUTE;
          OP_BEQ:       state_d = S_BRANCH;
`ifdef BNE_SUPPORT_EN
          OP_BNE:       state_d = S_BRANCH;
`endif
          OP_ADDI:      state_d = S_ADDIEX;
          OP_ORI:       state_d = S_ORIEX;
          OP_J:         state_d = S_JUMP;
          default: begin
            state_d    = S_FETCH;
            illegal_op = 1'b1;
          end
        endcase
      end
      S_MEMADR: begin
        alu_src_a = 1'b1;
        alu_src_b = 2'b10;
        state_d   = (opcode == OP_LW) ? S_MEMRD : S_MEMWR;
      end
      S_MEMRD: begin
        iord    = 1'b1;
        state_d = mem_ready ? S_MEMWB : S_MEMRD;
      end
      S_MEMWB: begin
        mem_to_reg = 1'b1;
        reg_write  = 1'b1;
      end
      S_MEMWR: begin
        iord      = 1'b1;
        mem_write = 1'b1;
        state_d   = mem_ready ? S_FETCH : S_MEMWR;
      end
      S_EXECUTE: begin
        alu_src_a = 1'b1;
        aluop     = 2'b10;
        state_d   = S_ALUWB;
      end
      S_ALUWB: begin
        reg_dst   = 1'b1;
        reg_write = 1'b1;
      end
      S_BRANCH: begin
        alu_src_a = 1'b1;
        aluop     = 2'b01;
        pc_src    = 2'b01;
`ifdef BNE_SUPPORT_EN
        pc_en     = (opcode == OP_BNE) ? ~zero : zero;
`else
        pc_en     = zero;
`endif
      end
      S_ADDIEX: begin
        alu_src_a = 1'b1;
        alu_src_b = 2'b10;
        state_d   = S_IMMWB;
      end
      S_ORIEX: begin
        alu_src_a = 1'b1;
        alu_src_b = 2'b10;
        imm_zext  = 1'b1;
        aluop     = 2'b11;
        state_d   = S_IMMWB;
      end
      S_IMMWB: begin
        reg_write = 1'b1;
      end
      S_JUMP: begin
        pc_src = 2'b10;
        pc_en  = 1'b1;
      end
      default: state_d = S_FETCH;
    endcase

    if (!rst_n) begin
      pc_en      = 1'b0;
      ir_write   = 1'b0;
      mem_write  = 1'b0;
      reg_write  = 1'b0;
      illegal_op = 1'b0;
    end
  end

  assign alu_in      = {aluop, (aluop == 2'b10) ? funct : 6'b000000};
  assign mem_timeout = timeout;
  assign state_dbg   = state_eff;

endmodule
`default_nettype wire

// File: tb/tb_mips_mc_control.sv
`default_nettype none
// +--------------------------------------------------------------------------+
// | tb_mips_mc_control : directed + randomized bench for mips_mc_control,     |
// |                      checked against an instruction-path reference model.|
// | Revision 1.0                                                              |
// +--------------------------------------------------------------------------+
module tb_mips_mc_control;

  localparam int FETCH_WAIT_MAX = 8;

  logic       clk, rst_n, zero, mem_ready;
  logic [5:0] opcode, funct;
  logic [7:0] alu_in;
  logic       pc_en, iord, mem_write, ir_write, reg_dst, mem_to_reg, reg_write, alu_src_a;
  logic [1:0] alu_src_b, pc_src;
  logic       imm_zext, illegal_op, mem_timeout;
  logic [3:0] state_dbg;

  mips_mc_control #(.FETCH_WAIT_MAX(FETCH_WAIT_MAX)) dut (
    .clk(clk), .rst_n(rst_n), .opcode(opcode), .funct(funct), .zero(zero),
    .mem_ready(mem_ready), .alu_in(alu_in), .pc_en(pc_en), .iord(iord),
    .mem_write(mem_write), .ir_write(ir_write), .reg_dst(reg_dst),
    .mem_to_reg(mem_to_reg), .reg_write(reg_write), .alu_src_a(alu_src_a),
    .alu_src_b(alu_src_b), .imm_zext(imm_zext), .pc_src(pc_src),
    .illegal_op(illegal_op), .mem_timeout(mem_timeout), .state_dbg(state_dbg)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  int n_vec = 0;
  int n_err = 0;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_vec++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s got=%0h exp=%0h at %0t", tag, got, exp, $time);
    end
  endtask

  // Reference model: each instruction is a fixed path of states; wait states
  // repeat while memory is not ready.
  int         m_path[$];
  int         m_idx   = 0;
  int         m_stall = 0;
  bit         need_new = 1;
  bit         use_forced = 0;
  logic [5:0] forced_op, forced_fn;

  function automatic bit is_legal(input logic [5:0] op);
    case (op)
      6'b100011, 6'b101011, 6'b000000, 6'b000100,
      6'b001000, 6'b001101, 6'b000010: return 1;
`ifdef BNE_SUPPORT_EN
      6'b000101: return 1;
`endif
      default: return 0;
    endcase
  endfunction

  function automatic bit is_wait(input int st);
    return (st == 0) || (st == 3) || (st == 5);
  endfunction

  task automatic build_path(input logic [5:0] op);
    case (op)
      6'b100011: m_path = '{0, 1, 2, 3, 4};
      6'b101011: m_path = '{0, 1, 2, 5};
      6'b000000: m_path = '{0, 1, 6, 7};
      6'b000100: m_path = '{0, 1, 8};
      6'b001000: m_path = '{0, 1, 9, 10};
      6'b001101: m_path = '{0, 1, 11, 10};
      6'b000010: m_path = '{0, 1, 12};
      default:   m_path = is_legal(op) ? '{0, 1, 8} : '{0, 1};
    endcase
  endtask

  // Packed {alu_in, pc_en, iord, mem_write, ir_write, reg_dst, mem_to_reg,
  // reg_write, alu_src_a, alu_src_b, imm_zext, pc_src, illegal_op}.
  function automatic logic [21:0] exp_out(input int st_in, input logic rn, input logic mr,
                                          input logic z, input logic [5:0] op, input logic [5:0] fn);
    int st;
    logic [1:0] aop, asb, psrc;
    logic pe, io, mw, irw, rd, m2r, rw, asa, iz, ill;
    st = rn ? st_in : 0;
    aop = 0; asb = 0; psrc = 0;
    pe = 0; io = 0; mw = 0; irw = 0; rd = 0; m2r = 0; rw = 0; asa = 0; iz = 0; ill = 0;
    case (st)
      0:  begin asb = 2'b01; irw = mr; pe = mr; end
      1:  begin asb = 2'b11; ill = !is_legal(op); end
      2:  begin asa = 1; asb = 2'b10; end
      3:  io = 1;
      4:  begin m2r = 1; rw = 1; end
      5:  begin io = 1; mw = 1; end
      6:  begin asa = 1; aop = 2'b10; end
      7:  begin rd = 1; rw = 1; end
      8:  begin asa = 1; aop = 2'b01; psrc = 2'b01; pe = (op == 6'b000101) ? ~z : z; end
      9:  begin asa = 1; asb = 2'b10; end
      10: rw = 1;
      11: begin asa = 1; asb = 2'b10; iz = 1; aop = 2'b11; end
      12: begin psrc = 2'b10; pe = 1; end
      default: ;
    endcase
    if (!rn) begin pe = 0; irw = 0; mw = 0; rw = 0; ill = 0; end
    return {aop, (aop == 2'b10) ? fn : 6'b0, pe, io, mw, irw, rd, m2r, rw, asa, asb, iz, psrc, ill};
  endfunction

  function automatic logic [5:0] random_op();
    logic [5:0] op;
    case ($urandom_range(0, 8))
      0: op = 6'b100011;
      1: op = 6'b101011;
      2: op = 6'b000000;
      3: op = 6'b000100;
      4: op = 6'b001000;
      5: op = 6'b001101;
      6: op = 6'b000010;
      7: op = 6'b000101;
      default: begin
        op = 6'($urandom);
        while (is_legal(op) || op == 6'b000101) op = 6'($urandom);
      end
    endcase
    return op;
  endfunction

  // One clock: drive at the falling edge, check, then advance the model to
  // what the rising edge should produce.
  task automatic step(input logic rn, input logic mr, input logic z);
    int st;
    bit exp_to;
    logic [21:0] got;
    rst_n = rn; mem_ready = mr; zero = z;
    if (rn && need_new) begin
      if (use_forced) begin
        opcode = forced_op; funct = forced_fn; use_forced = 0;
      end else begin
        opcode = random_op(); funct = 6'($urandom);
      end
      build_path(opcode);
      need_new = 0;
    end
    #1;
    st = (rn && m_path.size() > 0) ? m_path[m_idx] : 0;
    exp_to = rn && is_wait(st) && (FETCH_WAIT_MAX != 0) && (m_stall == FETCH_WAIT_MAX);
    got = {alu_in, pc_en, iord, mem_write, ir_write, reg_dst, mem_to_reg, reg_write,
           alu_src_a, alu_src_b, imm_zext, pc_src, illegal_op};
    check("state", 32'(state_dbg), 32'(st));
    check("outputs", 32'(got), 32'(exp_out(st, rn, mr, z, opcode, funct)));
    check("mem_timeout", 32'(mem_timeout), 32'(exp_to));

    if (!rn) begin
      m_idx = 0; m_stall = 0; need_new = 1;
    end else if (is_wait(st) && !mr) begin
      m_stall = exp_to ? 0 : m_stall + 1;
    end else begin
      m_stall = 0;
      m_idx++;
      if (m_idx >= m_path.size()) begin
        m_idx = 0; need_new = 1;
      end
    end
    @(negedge clk);
  endtask

  task automatic force_instr(input logic [5:0] op, input logic [5:0] fn);
    forced_op = op; forced_fn = fn; use_forced = 1;
  endtask

  initial begin
    rst_n = 0; mem_ready = 1; zero = 0; opcode = 0; funct = 0;
    @(negedge clk);

    // Reset with memory ready, then release
    step(0, 1, 0);
    step(0, 1, 0);

    // R-type sub: 0,1,6,7
    force_instr(6'b000000, 6'b100010);
    repeat (4) step(1, 1, 0);

    // lw with three MEMRD stalls: 8 cycles
    force_instr(6'b100011, 6'h00);
    step(1, 1, 0); step(1, 1, 0); step(1, 1, 0);
    step(1, 0, 0); step(1, 0, 0); step(1, 0, 0);
    step(1, 1, 0); step(1, 1, 0);

    // beq taken then not taken
    force_instr(6'b000100, 6'h3f);
    repeat (3) step(1, 1, 1);
    force_instr(6'b000100, 6'h3f);
    repeat (3) step(1, 1, 0);

    // ori, then an illegal opcode, then bne
    force_instr(6'b001101, 6'h15);
    repeat (4) step(1, 1, 0);
    force_instr(6'b111111, 6'h00);
    repeat (2) step(1, 1, 0);
    force_instr(6'b000101, 6'h00);
    repeat (3) step(1, 1, 1);

    // Ten FETCH stalls: timeout after the eighth, state held
    force_instr(6'b000010, 6'h00);
    repeat (10) step(1, 0, 0);
    repeat (3) step(1, 1, 0);

    // sw stalling in MEMWR long enough to time out, then reset mid-instruction
    force_instr(6'b101011, 6'h00);
    repeat (3) step(1, 1, 0);
    repeat (12) step(1, 0, 0);
    step(1, 1, 0);
    force_instr(6'b001000, 6'h00);
    repeat (3) step(1, 1, 0);
    step(0, 1, 0);
    repeat (4) step(1, 1, 0);

    // Randomized traffic with occasional long stalls and resets
    for (int i = 0; i < 4000; i++) begin
      logic rn, mr;
      rn = ($urandom_range(0, 99) != 0);
      if ((i / 40) % 5 == 4) mr = ($urandom_range(0, 9) == 0);
      else mr = ($urandom_range(0, 3) != 0);
      step(rn, mr, 1'($urandom));
    end

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
`default_nettype wire
